pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage MIPS core on the NoC tile. It sequences the IF/ID, ID/EX and EX/MEM pipeline registers by driving their stall (hold) and flush (bubble) controls. It handles load-use interlock, branch/jump flush and NoC send/receive back-pressure. It also issues registered forwarding selects that enter EX together with the instruction.

Parameters:
TIMEOUT_CYC, 256, cycles a NoC wait may last before abort (used only with the optional feature)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset (asserted at 0)
Rs_D  in  5  source register A of the instruction in decode
Rt_D  in  5  source register B of the instruction in decode
Radd_E  in  5  destination register of the instruction in execute
RegW_enable_E  in  1  instruction in execute writes the register file
Mem_Read_E  in  1  instruction in execute is a load
Radd_M  in  5  destination register of the instruction in memory stage
RegW_enable_M  in  1  instruction in memory stage writes the register file
branch_taken_E  in  1  branch resolved taken in execute
Jump_E  in  1  jump in execute
proc_valid_E  in  1  instruction in execute sends a packet to the router
proc_ready_in_E  in  1  instruction in execute waits for a packet from the router
noc_ready  in  1  router accepts the send this cycle
noc_valid  in  1  router delivers a packet this cycle
stall_F  out  1  hold PC
stall_D  out  1  hold IF/ID
stall_E  out  1  hold ID/EX
flush_D  out  1  clear IF/ID
flush_E  out  1  clear ID/EX (insert bubble)
fwdA_E  out  2  operand A select in execute: 00 = register file, 10 = MEM result, 01 = WB result
fwdB_E  out  2  operand B select, same encoding as fwdA_E
noc_timeout  out  1  one-cycle abort pulse
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst = 0, asynchronous): FSM returns to IDLE; fwdA_E/fwdB_E = 00; stall_cnt = 0; timer = 0; noc_timeout = 0. All combinational outputs are forced to 0 while reset is held.
- Register 0 is never a hazard. Any compare where the register equals 0 yields no match.
- Forwarding, registered at the D→E boundary:
  - Next fwdA_E = 10 if RegW_enable_E && Radd_E == Rs_D.
  - Else 01 if RegW_enable_M && Radd_M == Rs_D.
  - Else 00.
  - fwdB_E follows the same rule using Rt_D.
  - The selects update only when stall_E = 0.
  - flush_E loads 00.
  - Register file is write-through, so no WB-to-D forwarding is needed.
- Load-use interlock (combinational):
  - lu = Mem_Read_E && RegW_enable_E && Radd_E != 0 && (Radd_E == Rs_D || Radd_E == Rt_D).
  - lu → stall_F = stall_D = 1 and flush_E = 1, for exactly 1 cycle.
  - On the following cycle the dependent instruction sees fwd = 01.
- Branch/jump: (branch_taken_E || Jump_E) → flush_D = flush_E = 1 for 1 cycle; this suppresses lu in the same cycle.
- NoC FSM, states IDLE, SEND_WAIT, RECV_WAIT:
  - IDLE:
    - proc_valid_E && !noc_ready → SEND_WAIT.
    - Else proc_ready_in_E && !noc_valid → RECV_WAIT.
    - Send is evaluated before receive.
  - SEND_WAIT:
    - noc_ready → RECV_WAIT if proc_ready_in_E && !noc_valid.
    - noc_ready otherwise → IDLE.
  - RECV_WAIT: noc_valid → IDLE.
  - noc_stall = (IDLE && entry condition true) || (SEND_WAIT && !noc_ready) || (RECV_WAIT && !noc_valid).
  - A handshake completing in the same cycle does not stall.
  - noc_stall → stall_F = stall_D = stall_E = 1.
- Priority: noc_stall > branch flush > load-use.
  - During noc_stall, flush_D = flush_E = 0 and lu is ignored.
  - lu is re-evaluated once the stall is released.
- stall_cnt increments on every cycle with stall_D = 1 and saturates at all-ones.
- Timer: cleared in IDLE; increments each cycle in SEND_WAIT or RECV_WAIT.

Optional Feature:
NOC_TIMEOUT_EN
- Defined:
  - When the timer reaches TIMEOUT_CYC − 1 while still waiting, noc_timeout pulses for 1 cycle.
  - In that cycle the FSM returns to IDLE, all stalls are released and flush_E = 1, so the NoC instruction is dropped.
- Undefined:
  - Waits are unbounded.
  - noc_timeout is tied to 0.
  - The timer logic is not built.

Decomposition:
- Shared package contents:
  - FSM state encoding (IDLE = 2'd0, SEND_WAIT = 2'd1, RECV_WAIT = 2'd2).
  - Forward-select constants FWD_RF = 2'b00, FWD_MEM = 2'b10, FWD_WB = 2'b01.
  - Register-address width 5.
- One natural sub-module: noc_wait_fsm (FSM plus timer, outputs noc_stall and noc_timeout). Forwarding, load-use and priority logic stay in the top module.

Test Plan:
- lw $5 in E (Mem_Read_E = 1, Radd_E = 5), Rs_D = 5 → 1 cycle with stall_F = stall_D = flush_E = 1; next cycle fwdA_E = 01; stall_cnt = 1.
- add writes $7 in E, Rt_D = 7 → no stall; next cycle fwdB_E = 10. Repeat with Radd_E = 0 → fwdB_E = 00.
- branch_taken_E = 1 with a simultaneous load-use match → flush_D = flush_E = 1, stall_D = 0, for exactly 1 cycle.
- proc_valid_E = 1, noc_ready held 0 for 5 cycles then 1 → stall_E high for 5 cycles, released in the ready cycle; state returns to IDLE.
- proc_valid_E = proc_ready_in_E = 1, noc_ready after 3 cycles, noc_valid after 2 more → SEND_WAIT (3 cycles) → RECV_WAIT (2 cycles) → IDLE; stall_cnt = 5.
- NOC_TIMEOUT_EN, TIMEOUT_CYC = 8, noc_ready stuck at 0 → noc_timeout pulses on the 8th wait cycle with flush_E = 1; rst pulled low mid-wait → all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Contents: NoC wait state encoding, forward-select codes, register-compare helper.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_WAIT = 2'd1,
    RECV_WAIT = 2'd2
  } noc_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // $0 is hard-wired, so it never creates a dependency
  function automatic logic reg_hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_noc_wait_fsm.sv
// NoC send/receive back-pressure tracker; raises noc_stall while a handshake is pending.
// With NOC_TIMEOUT_EN defined, a wait lasting TIMEOUT_CYC cycles aborts with a noc_timeout pulse.
//
//   state     | meaning
//   IDLE      | no NoC transfer outstanding
//   SEND_WAIT | send issued, waiting for noc_ready
//   RECV_WAIT | receive issued, waiting for noc_valid
module pipe_hazard_ctrl_noc_wait_fsm
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic proc_valid_E,
  input  logic proc_ready_in_E,
  input  logic noc_ready,
  input  logic noc_valid,
  output logic noc_stall,
  output logic noc_timeout
);

  noc_state_e state;
  logic send_req, recv_req, waiting, expire;

  assign send_req = proc_valid_E && !noc_ready;
  assign recv_req = proc_ready_in_E && !noc_valid;

  always_comb begin
    waiting = 1'b0;
    case (state)
      IDLE:      waiting = send_req || recv_req;
      SEND_WAIT: waiting = !noc_ready;
      RECV_WAIT: waiting = !noc_valid;
      default:   waiting = 1'b0;
    endcase
  end

`ifdef NOC_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] timer;

  assign expire = (state != IDLE) && waiting && (timer == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               timer <= '0;
    else if (state == IDLE) timer <= '0;
    else                    timer <= timer + TMR_W'(1);
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign expire = 1'b0;
`endif

  assign noc_stall   = waiting && !expire;
  assign noc_timeout = expire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (expire) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (send_req)      state <= SEND_WAIT;
          else if (recv_req) state <= RECV_WAIT;
        end
        SEND_WAIT: if (noc_ready) state <= recv_req ? RECV_WAIT : IDLE;
        RECV_WAIT: if (noc_valid) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use interlock, branch/jump flush,
// NoC back-pressure stalls and registered EX forwarding selects. Optional: NOC_TIMEOUT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs_D,
  input  logic [REG_W-1:0] Rt_D,
  input  logic [REG_W-1:0] Radd_E,
  input  logic             RegW_enable_E,
  input  logic             Mem_Read_E,
  input  logic [REG_W-1:0] Radd_M,
  input  logic             RegW_enable_M,
  input  logic             branch_taken_E,
  input  logic             Jump_E,
  input  logic             proc_valid_E,
  input  logic             proc_ready_in_E,
  input  logic             noc_ready,
  input  logic             noc_valid,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             flush_D,
  output logic             flush_E,
  output logic [1:0]       fwdA_E,
  output logic [1:0]       fwdB_E,
  output logic             noc_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  logic noc_stall, noc_abort, lu, redirect;
  logic stall_fd, stall_ex, flush_ifid, flush_idex;
  logic [1:0] fwd_a_next, fwd_b_next;

  pipe_hazard_ctrl_noc_wait_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_noc_wait (
    .clk             (clk),
    .rst             (rst),
    .proc_valid_E    (proc_valid_E),
    .proc_ready_in_E (proc_ready_in_E),
    .noc_ready       (noc_ready),
    .noc_valid       (noc_valid),
    .noc_stall       (noc_stall),
    .noc_timeout     (noc_abort)
  );

  assign redirect = branch_taken_E || Jump_E;
  assign lu = Mem_Read_E && RegW_enable_E &&
              (reg_hit(Radd_E, Rs_D) || reg_hit(Radd_E, Rt_D));

  // NoC stall dominates; an aborted NoC instruction is bubbled out of EX
  always_comb begin
    stall_fd   = 1'b0;
    stall_ex   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (noc_stall) begin
      stall_fd = 1'b1;
      stall_ex = 1'b1;
    end else if (noc_abort) begin
      flush_idex = 1'b1;
      flush_ifid = redirect;
    end else if (redirect) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (lu) begin
      stall_fd   = 1'b1;
      flush_idex = 1'b1;
    end
  end

  always_comb begin
    fwd_a_next = FWD_RF;
    fwd_b_next = FWD_RF;
    if (RegW_enable_E && reg_hit(Radd_E, Rs_D))      fwd_a_next = FWD_MEM;
    else if (RegW_enable_M && reg_hit(Radd_M, Rs_D)) fwd_a_next = FWD_WB;
    if (RegW_enable_E && reg_hit(Radd_E, Rt_D))      fwd_b_next = FWD_MEM;
    else if (RegW_enable_M && reg_hit(Radd_M, Rt_D)) fwd_b_next = FWD_WB;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwdA_E    <= FWD_RF;
      fwdB_E    <= FWD_RF;
      stall_cnt <= '0;
    end else begin
      if (flush_idex) begin
        fwdA_E <= FWD_RF;
        fwdB_E <= FWD_RF;
      end else if (!stall_ex) begin
        fwdA_E <= fwd_a_next;
        fwdB_E <= fwd_b_next;
      end
      if (stall_fd && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign stall_F     = rst & stall_fd;
  assign stall_D     = rst & stall_fd;
  assign stall_E     = rst & stall_ex;
  assign flush_D     = rst & flush_ifid;
  assign flush_E     = rst & flush_idex;
  assign noc_timeout = rst & noc_abort;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: interlock, forwarding, flush, NoC waits, saturation, reset.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs_D, Rt_D, Radd_E, Radd_M;
  logic        RegW_enable_E, Mem_Read_E, RegW_enable_M;
  logic        branch_taken_E, Jump_E, proc_valid_E, proc_ready_in_E, noc_ready, noc_valid;
  logic        stall_F, stall_D, stall_E, flush_D, flush_E, noc_timeout;
  logic [1:0]  fwdA_E, fwdB_E;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT_CYC(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Radd_E(Radd_E), .RegW_enable_E(RegW_enable_E),
    .Mem_Read_E(Mem_Read_E), .Radd_M(Radd_M), .RegW_enable_M(RegW_enable_M),
    .branch_taken_E(branch_taken_E), .Jump_E(Jump_E),
    .proc_valid_E(proc_valid_E), .proc_ready_in_E(proc_ready_in_E),
    .noc_ready(noc_ready), .noc_valid(noc_valid),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .flush_D(flush_D), .flush_E(flush_E),
    .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
    .noc_timeout(noc_timeout), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs_D = 0; Rt_D = 0; Radd_E = 0; Radd_M = 0;
    RegW_enable_E = 0; Mem_Read_E = 0; RegW_enable_M = 0;
    branch_taken_E = 0; Jump_E = 0;
    proc_valid_E = 0; proc_ready_in_E = 0; noc_ready = 0; noc_valid = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    #2;
    // reset held with stall-provoking inputs: combinational outputs stay 0
    proc_valid_E = 1; Mem_Read_E = 1; RegW_enable_E = 1; Radd_E = 5; Rs_D = 5; branch_taken_E = 1;
    #10;
    check("rst stall_F", stall_F, 0);
    check("rst stall_E", stall_E, 0);
    check("rst flush_E", flush_E, 0);
    check("rst fwdA", fwdA_E, 0);
    check("rst cnt", stall_cnt, 0);
    clear_inputs();
    mid();
    rst = 1'b1;
    tick();

    // load-use: lw $5 in E, Rs_D = 5
    Mem_Read_E = 1; RegW_enable_E = 1; Radd_E = 5; Rs_D = 5; Rt_D = 3;
    mid();
    check("lu stall_F", stall_F, 1);
    check("lu stall_D", stall_D, 1);
    check("lu stall_E", stall_E, 0);
    check("lu flush_E", flush_E, 1);
    check("lu flush_D", flush_D, 0);
    tick();
    check("lu fwdA bubble", fwdA_E, 0);
    check("lu cnt", stall_cnt, 1);
    Mem_Read_E = 0; RegW_enable_E = 0; Radd_E = 0; Radd_M = 5; RegW_enable_M = 1;
    mid();
    check("lu release stall_D", stall_D, 0);
    check("lu release flush_E", flush_E, 0);
    tick();
    check("lu fwdA wb", fwdA_E, 1);
    check("lu fwdB rf", fwdB_E, 0);

    // forwarding patterns
    clear_inputs();
    RegW_enable_E = 1; Radd_E = 7; Rt_D = 7;
    mid();
    check("fwd no stall", stall_D, 0);
    tick();
    check("fwdB mem", fwdB_E, 2);
    check("fwdA rf", fwdA_E, 0);
    Radd_E = 0; Rt_D = 0;
    tick();
    check("fwdB r0", fwdB_E, 0);
    Radd_E = 9; RegW_enable_M = 1; Radd_M = 9; Rs_D = 9; Rt_D = 9;
    tick();
    check("fwdA mem prio", fwdA_E, 2);
    check("fwdB mem prio", fwdB_E, 2);
    RegW_enable_E = 0;
    tick();
    check("fwdA wb", fwdA_E, 1);
    check("fwdB wb", fwdB_E, 1);
    Radd_M = 0; Rs_D = 0; Rt_D = 0;
    tick();
    check("fwdA r0 in M", fwdA_E, 0);

    // branch with simultaneous load-use
    clear_inputs();
    Mem_Read_E = 1; RegW_enable_E = 1; Radd_E = 4; Rs_D = 4; branch_taken_E = 1;
    mid();
    check("br flush_D", flush_D, 1);
    check("br flush_E", flush_E, 1);
    check("br stall_D", stall_D, 0);
    check("br stall_F", stall_F, 0);
    tick();
    check("br fwdA", fwdA_E, 0);
    check("br cnt", stall_cnt, 1);
    clear_inputs();
    Jump_E = 1;
    mid();
    check("jmp flush_D", flush_D, 1);
    tick();
    clear_inputs();
    mid();
    check("post flush_D", flush_D, 0);
    check("post flush_E", flush_E, 0);
    tick();

    // send wait: noc_ready low for 5 cycles; branch + lu inside the stall are ignored
    proc_valid_E = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        branch_taken_E = 1; Mem_Read_E = 1; RegW_enable_E = 1; Radd_E = 6; Rs_D = 6;
      end
      mid();
      check("send stall_E", stall_E, 1);
      if (i == 2) begin
        check("send flush_D", flush_D, 0);
        check("send flush_E", flush_E, 0);
      end
      tick();
      branch_taken_E = 0; Mem_Read_E = 0; RegW_enable_E = 0;
    end
    noc_ready = 1;
    mid();
    check("send ready stall_E", stall_E, 0);
    tick();
    clear_inputs();
    mid();
    check("send idle stall_E", stall_E, 0);
    tick();
    check("send cnt", stall_cnt, 6);

    // handshakes completing in the same cycle do not stall
    proc_valid_E = 1; noc_ready = 1;
    mid();
    check("send hs stall_E", stall_E, 0);
    tick();
    clear_inputs();
    proc_ready_in_E = 1; noc_valid = 1;
    mid();
    check("recv hs stall_E", stall_E, 0);
    tick();
    clear_inputs();

    // send then receive: ready after 3 cycles, valid 2 cycles later
    for (int c = 0; c < 7; c++) begin
      proc_valid_E = 1; proc_ready_in_E = 1;
      noc_ready = (c >= 3);
      noc_valid = (c == 6);
      mid();
      check("sr stall_E", stall_E, (c == 3 || c == 6) ? 0 : 1);
      tick();
    end
    clear_inputs();
    mid();
    check("sr idle stall_E", stall_E, 0);
    check("sr cnt", stall_cnt, 11);
    tick();

`ifdef NOC_TIMEOUT_EN
    proc_valid_E = 1;
    for (int c = 1; c <= 9; c++) begin
      mid();
      check("tmo pulse", noc_timeout, (c == 9) ? 1 : 0);
      check("tmo stall_E", stall_E, (c == 9) ? 0 : 1);
      check("tmo flush_E", flush_E, (c == 9) ? 1 : 0);
      tick();
    end
    mid();
    check("tmo one pulse", noc_timeout, 0);
    tick();
    clear_inputs();
    tick();
`endif

    // saturation of the stall counter under a held load-use
    Mem_Read_E = 1; RegW_enable_E = 1; Radd_E = 3; Rs_D = 3;
    repeat (65540) @(posedge clk);
    #1;
    check("sat cnt", stall_cnt, 16'hFFFF);
    mid();
    check("sat stall_D", stall_D, 1);
    tick();
    check("sat hold", stall_cnt, 16'hFFFF);

    // reset pulled mid-wait
    clear_inputs();
    RegW_enable_E = 1; Radd_E = 2; Rs_D = 2;
    tick();
    check("pre rst fwdA", fwdA_E, 2);
    clear_inputs();
    proc_valid_E = 1;
    tick();
    tick();
    mid();
    check("pre rst stall_E", stall_E, 1);
    tick();
    rst = 1'b0;
    #1;
    check("mid rst stall_E", stall_E, 0);
    check("mid rst stall_D", stall_D, 0);
    check("mid rst flush_E", flush_E, 0);
    check("mid rst tmo", noc_timeout, 0);
    check("mid rst cnt", stall_cnt, 0);
    check("mid rst fwdA", fwdA_E, 0);
    clear_inputs();
    mid();
    rst = 1'b1;
    tick();
    mid();
    check("post rst stall_E", stall_E, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
